// File: rtl/alu_pkg.sv
// Shared command/entry definitions for the ALU command sequencer and its FIFO.
package alu_pkg;

  localparam int unsigned CMD_W = 5;
  localparam int unsigned REP_W = 2;

  localparam int unsigned B_SEL_BIT = 4;
  localparam int unsigned OP_MSB    = 3;
  localparam int unsigned OP_LSB    = 0;

  typedef struct packed {
    logic [REP_W-1:0] rep;
    logic [CMD_W-1:0] cmd;
  } alu_entry_t;

  localparam int unsigned ENTRY_W = $bits(alu_entry_t);

  function automatic alu_entry_t mk_entry(input logic [CMD_W-1:0] cmd,
                                          input logic [REP_W-1:0] rep);
    alu_entry_t e;
    e.rep = rep;
    e.cmd = cmd;
    return e;
  endfunction

endpackage

// File: rtl/alu_cmd_fifo.sv
// Synchronous FIFO of command entries; head is read combinationally, push/pop take effect at the edge.
import alu_pkg::*;

module alu_cmd_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  alu_entry_t       i_data,
  input  logic             i_pop,
  output alu_entry_t       o_head,
  output logic [CNT_W-1:0] o_count,
  output logic             o_full,
  output logic             o_empty
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  alu_entry_t       r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  logic w_do_push;
  logic w_do_pop;

  assign o_full    = (r_count == CNT_W'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_head    = r_mem[r_rd_ptr];
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;

  always_ff @(posedge clk) begin
    if (w_do_push && !rst) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  // Pointers are exactly log2(DEPTH) wide, so wrap is the natural overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      if (w_do_push && !w_do_pop) begin
        r_count <= r_count + CNT_W'(1);
      end else if (w_do_pop && !w_do_push) begin
        r_count <= r_count - CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Queues host ALU commands with repeat counts and issues one cmd/noOp pair per clock to the decoder.
import alu_pkg::*;

module alu_cmd_sequencer #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             halt,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [CMD_W-1:0] in_cmd,
  input  logic [REP_W-1:0] in_rep,
  output logic [CMD_W-1:0] cmd,
  output logic             noOp,
  output logic             busy,
  output logic [CNT_W-1:0] count
);

  typedef enum logic [1:0] {
    ACT_HOLD,
    ACT_REPEAT,
    ACT_POP,
    ACT_IDLE
  } act_e;

  logic [CMD_W-1:0] r_cmd;
  logic [REP_W-1:0] r_left;
  logic             r_noop;

  act_e             w_act;
  logic [CMD_W-1:0] w_cmd_nxt;
  logic [REP_W-1:0] w_left_nxt;
  logic             w_noop_nxt;
  logic             w_pop;
  logic             w_push;
  logic             w_full;
  logic             w_empty;
  alu_entry_t       w_head;
  alu_entry_t       w_in_entry;
  logic [CNT_W-1:0] w_count;

  assign w_in_entry = mk_entry(in_cmd, in_rep);
  assign w_push     = in_valid && !w_full;

  alu_cmd_fifo #(
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_data  (w_in_entry),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_count (w_count),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  always_comb begin
    w_act = ACT_IDLE;
    if (halt) begin
      w_act = ACT_HOLD;
    end else if (r_left != '0) begin
      w_act = ACT_REPEAT;
    end else if (!w_empty) begin
      w_act = ACT_POP;
    end
  end

  // Halt leaves cmd/left untouched so the interrupted command resumes with exactly what it owed.
  always_comb begin
    w_cmd_nxt  = r_cmd;
    w_left_nxt = r_left;
    w_noop_nxt = 1'b1;
    w_pop      = 1'b0;
    unique case (w_act)
      ACT_HOLD: begin
        w_noop_nxt = 1'b1;
      end
      ACT_REPEAT: begin
        w_noop_nxt = 1'b0;
        w_left_nxt = r_left - REP_W'(1);
      end
      ACT_POP: begin
        w_pop      = 1'b1;
        w_noop_nxt = 1'b0;
        w_cmd_nxt  = w_head.cmd;
        w_left_nxt = w_head.rep;
      end
      ACT_IDLE: begin
        w_noop_nxt = 1'b1;
        w_cmd_nxt  = '0;
      end
      default: begin
        w_noop_nxt = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cmd  <= '0;
      r_left <= '0;
      r_noop <= 1'b1;
    end else begin
      r_cmd  <= w_cmd_nxt;
      r_left <= w_left_nxt;
      r_noop <= w_noop_nxt;
    end
  end

  assign cmd      = r_cmd;
  assign noOp     = r_noop;
  assign count    = w_count;
  assign in_ready = !w_full;
  assign busy     = !w_empty || (r_left != '0) || !r_noop;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed bench for alu_cmd_sequencer with a queue-based reference model checked every cycle.
module tb_alu_cmd_sequencer;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned CNT_W = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       halt = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [4:0] in_cmd = '0;
  logic [1:0] in_rep = '0;
  logic [4:0] cmd;
  logic       noOp;
  logic       busy;
  logic [CNT_W-1:0] count;

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en = 1'b0;

  alu_cmd_sequencer #(
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .halt     (halt),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_cmd   (in_cmd),
    .in_rep   (in_rep),
    .cmd      (cmd),
    .noOp     (noOp),
    .busy     (busy),
    .count    (count)
  );

  always #5 clk = ~clk;

  // Reference model: a queue of {rep,cmd} entries plus the command being issued and its owed issues.
  logic [6:0] mq[$];
  int         m_left = 0;
  logic [4:0] m_cmd = '0;
  logic       m_noop = 1'b1;
  bit         m_accept;
  logic [6:0] m_e;

  always @(posedge clk) begin
    if (rst) begin
      mq.delete();
      m_left = 0;
      m_cmd  = '0;
      m_noop = 1'b1;
    end else begin
      m_accept = in_valid && (mq.size() < DEPTH);
      if (halt) begin
        m_noop = 1'b1;
      end else if (m_left > 0) begin
        m_noop = 1'b0;
        m_left = m_left - 1;
      end else if (mq.size() > 0) begin
        m_e    = mq.pop_front();
        m_cmd  = m_e[4:0];
        m_left = int'(m_e[6:5]);
        m_noop = 1'b0;
      end else begin
        m_noop = 1'b1;
        m_cmd  = '0;
      end
      if (m_accept) mq.push_back({in_rep, in_cmd});
    end
  end

  task automatic chk(input string name, input int unsigned got, input int unsigned exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("model.cmd", cmd, m_cmd);
      chk("model.noOp", noOp, m_noop);
      chk("model.count", count, mq.size());
      chk("model.in_ready", in_ready, (mq.size() != DEPTH) ? 1 : 0);
      chk("model.busy", busy, (mq.size() > 0 || m_left > 0 || !m_noop) ? 1 : 0);
    end
  end

  task automatic step(input logic r, input logic h, input logic v,
                      input logic [4:0] c, input logic [1:0] rp);
    rst = r; halt = h; in_valid = v; in_cmd = c; in_rep = rp;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle(input logic h);
    step(1'b0, h, 1'b0, 5'b0, 2'b0);
  endtask

  task automatic expect_out(input string name, input logic en, input logic [4:0] c,
                            input int unsigned cnt);
    chk({name, ".noOp"}, noOp, en ? 0 : 1);
    chk({name, ".cmd"}, cmd, c);
    chk({name, ".count"}, count, cnt);
  endtask

  logic [4:0] seq3 [4] = '{5'b01010, 5'b01010, 5'b01010, 5'b10101};
  logic [4:0] seq4 [4] = '{5'b00001, 5'b00010, 5'b00011, 5'b00100};

  initial begin
    // Reset, then idle
    step(1'b1, 1'b0, 1'b0, 5'b0, 2'b0);
    chk_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      idle(1'b0);
      expect_out("idle", 1'b0, 5'b0, 0);
      chk("idle.in_ready", in_ready, 1);
      chk("idle.busy", busy, 0);
    end

    // Single push, minimum latency
    step(1'b0, 1'b0, 1'b1, 5'b10101, 2'd0);
    expect_out("single.E", 1'b0, 5'b0, 1);
    idle(1'b0);
    expect_out("single.E1", 1'b1, 5'b10101, 0);
    idle(1'b0);
    expect_out("single.E2", 1'b0, 5'b0, 0);
    chk("single.busy", busy, 0);

    // Repeat then back-to-back with no bubble
    step(1'b0, 1'b0, 1'b1, 5'b01010, 2'd2);
    step(1'b0, 1'b0, 1'b1, 5'b10101, 2'd0);
    chk("b2b.count_pushpop", count, 1);
    for (int i = 0; i < 4; i++) begin
      chk("b2b.noOp", noOp, 0);
      chk("b2b.cmd", cmd, seq3[i]);
      if (i < 3) idle(1'b0);
    end
    idle(1'b0);
    expect_out("b2b.end", 1'b0, 5'b0, 0);

    // Fill while halted; fifth push dropped
    for (int i = 0; i < 5; i++) begin
      if (i == 4) chk("fill.in_ready_full", in_ready, 0);
      step(1'b0, 1'b1, 1'b1, (i == 4) ? 5'b11111 : 5'(i + 1), 2'd0);
      chk("fill.count", count, (i < 4) ? i + 1 : 4);
      chk("fill.noOp", noOp, 1);
    end
    chk("fill.in_ready", in_ready, 0);
    for (int i = 0; i < 4; i++) begin
      idle(1'b0);
      expect_out("drain", 1'b1, seq4[i], 3 - i);
      chk("drain.in_ready", in_ready, 1);
    end
    idle(1'b0);
    expect_out("drain.end", 1'b0, 5'b0, 0);

    // Halt in the middle of a rep=3 command
    step(1'b0, 1'b0, 1'b1, 5'b01010, 2'd3);
    idle(1'b0);
    expect_out("halt.i1", 1'b1, 5'b01010, 0);
    idle(1'b0);
    expect_out("halt.i2", 1'b1, 5'b01010, 0);
    for (int i = 0; i < 2; i++) begin
      idle(1'b1);
      expect_out("halt.held", 1'b0, 5'b01010, 0);
      chk("halt.busy", busy, 1);
    end
    idle(1'b0);
    expect_out("halt.i3", 1'b1, 5'b01010, 0);
    idle(1'b0);
    expect_out("halt.i4", 1'b1, 5'b01010, 0);
    idle(1'b0);
    expect_out("halt.end", 1'b0, 5'b0, 0);

    // Reset mid-repeat with two entries queued; push at the reset edge is dropped
    step(1'b0, 1'b0, 1'b1, 5'b00111, 2'd3);
    idle(1'b0);
    step(1'b0, 1'b0, 1'b1, 5'b01100, 2'd1);
    step(1'b0, 1'b0, 1'b1, 5'b10011, 2'd0);
    expect_out("rst.before", 1'b1, 5'b00111, 2);
    step(1'b1, 1'b1, 1'b1, 5'b11100, 2'd2);
    expect_out("rst.after", 1'b0, 5'b0, 0);
    chk("rst.busy", busy, 0);
    chk("rst.in_ready", in_ready, 1);
    for (int i = 0; i < 4; i++) begin
      idle(1'b0);
      expect_out("rst.quiet", 1'b0, 5'b0, 0);
    end

    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
